// File: rtl/lif_neuron_if.sv
// Signal bundle between the ECG encoder side and the LIF neuron.
// No backpressure: spike_i is a level, cfg_load_i a one-cycle strobe, and the outputs are valid every cycle.
interface lif_neuron_if #(
    parameter int WIDTH = 16
);
    logic             spike_i;
    logic [WIDTH-1:0] weight_i;
    logic [WIDTH-1:0] vth_i;
    logic             cfg_load_i;
    logic             spike_o;
    logic [WIDTH-1:0] vmem_o;
    logic             refractory_o;
    logic [1:0]       state;

    modport master (
        output spike_i, weight_i, vth_i, cfg_load_i,
        input  spike_o, vmem_o, refractory_o, state
    );

    modport slave (
        input  spike_i, weight_i, vth_i, cfg_load_i,
        output spike_o, vmem_o, refractory_o, state
    );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates a weight on each rising spike edge,
// leaks on a divided tick, fires at threshold, then sits out a refractory period.
module lif_neuron #(
    parameter int WIDTH          = 16,
    parameter int TICK_DIV       = 1200000,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_TICKS  = 4,
    parameter int DEFAULT_WEIGHT = 20,
    parameter int DEFAULT_VTH    = 100
) (
    input logic         clk_i,
    input logic         rst_i,
    lif_neuron_if.slave nrn
);
    typedef enum logic [1:0] {
        ST_INTEGRATE  = 2'd0,
        ST_REFRACTORY = 2'd1
    } state_t;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RC_W  = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [RC_W-1:0]  RC_LOAD   = RC_W'(REFRACT_TICKS);
    localparam logic [RC_W-1:0]  RC_ONE    = RC_W'(1);
    localparam logic [WIDTH-1:0] VMAX      = '1;
    localparam logic [WIDTH-1:0] VTH_MIN   = WIDTH'(1);

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] vmem_q, vmem_nxt;
    logic             fire_q, fire_nxt;
    logic [RC_W-1:0]  rcnt_q, rcnt_nxt;
    logic [CNT_W-1:0] tick_cnt_q;
    logic             spike_prev_q;
    logic [WIDTH-1:0] weight_q, vth_q;

    logic             tick;
    logic             evt;
    logic [WIDTH-1:0] leaked;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] v_int;
    logic [WIDTH-1:0] vth_eff;

    assign tick = (tick_cnt_q == TICK_LAST);
    assign evt  = nrn.spike_i & ~spike_prev_q;

    // Leak before add when tick and event coincide; add is one bit wider so it can clamp.
    assign leaked  = tick ? (vmem_q - (vmem_q >> LEAK_SHIFT)) : vmem_q;
    assign sum     = {1'b0, leaked} + {1'b0, weight_q};
    assign v_int   = evt ? (sum[WIDTH] ? VMAX : sum[WIDTH-1:0]) : leaked;
    assign vth_eff = (vth_q == '0) ? VTH_MIN : vth_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= ST_INTEGRATE;
            vmem_q       <= '0;
            fire_q       <= 1'b0;
            rcnt_q       <= '0;
            tick_cnt_q   <= '0;
            spike_prev_q <= 1'b0;
            weight_q     <= WIDTH'(DEFAULT_WEIGHT);
            vth_q        <= WIDTH'(DEFAULT_VTH);
        end else begin
            state_q      <= state_nxt;
            vmem_q       <= vmem_nxt;
            fire_q       <= fire_nxt;
            rcnt_q       <= rcnt_nxt;
            tick_cnt_q   <= tick ? '0 : tick_cnt_q + CNT_W'(1);
            spike_prev_q <= nrn.spike_i;
            if (nrn.cfg_load_i) begin
                weight_q <= nrn.weight_i;
                vth_q    <= nrn.vth_i;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        vmem_nxt  = vmem_q;
        fire_nxt  = 1'b0;
        rcnt_nxt  = rcnt_q;
        case (state_q)
            ST_INTEGRATE: begin
                if (v_int >= vth_eff) begin
                    vmem_nxt = '0;
                    fire_nxt = 1'b1;
                    if (REFRACT_TICKS > 0) begin
                        state_nxt = ST_REFRACTORY;
                        rcnt_nxt  = RC_LOAD;
                    end
                end else begin
                    vmem_nxt = v_int;
                end
            end
            ST_REFRACTORY: begin
                // Events arriving here are dropped, not deferred.
                vmem_nxt = '0;
                if (tick) begin
                    if (rcnt_q <= RC_ONE) begin
                        state_nxt = ST_INTEGRATE;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt_q - RC_ONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_INTEGRATE;
                vmem_nxt  = '0;
                rcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        nrn.spike_o      = fire_q;
        nrn.vmem_o       = vmem_q;
        nrn.refractory_o = (state_q == ST_REFRACTORY);
        nrn.state        = state_q;
    end
endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: directed scenarios plus random traffic, checked against
// a cycle-level reference model through an expected-output queue.
module tb_lif_neuron;
    localparam int WIDTH  = 16;
    localparam int TDIV   = 8;
    localparam int LSHIFT = 3;
    localparam int RTICKS = 4;
    localparam int DEF_W  = 20;
    localparam int DEF_TH = 100;
    localparam int VMAXI  = (1 << WIDTH) - 1;
    localparam int EW     = WIDTH + 2;

    logic clk;
    logic rst;

    lif_neuron_if #(.WIDTH(WIDTH)) nrn_if ();

    lif_neuron #(
        .WIDTH(WIDTH), .TICK_DIV(TDIV), .LEAK_SHIFT(LSHIFT),
        .REFRACT_TICKS(RTICKS), .DEFAULT_WEIGHT(DEF_W), .DEFAULT_VTH(DEF_TH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .nrn(nrn_if.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model state, in plain integers
    int m_vmem, m_refr_left, m_tick_cnt, m_weight, m_vth;
    bit m_prev, m_fire;

    logic [EW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic model_step(input bit r, input bit s, input bit c,
                              input int w, input int th);
        bit tk, ev;
        int v, thr;
        if (!r) begin
            m_vmem = 0; m_fire = 0; m_refr_left = 0; m_prev = 0;
            m_tick_cnt = 0; m_weight = DEF_W; m_vth = DEF_TH;
        end else begin
            tk = (m_tick_cnt == TDIV - 1);
            m_tick_cnt = tk ? 0 : m_tick_cnt + 1;
            ev = s && !m_prev;
            m_prev = s;
            if (m_refr_left > 0) begin
                m_fire = 0;
                m_vmem = 0;
                if (tk) m_refr_left = m_refr_left - 1;
            end else begin
                v = m_vmem;
                if (tk) v = v - v / (1 << LSHIFT);
                if (ev) v = (v + m_weight > VMAXI) ? VMAXI : v + m_weight;
                thr = (m_vth == 0) ? 1 : m_vth;
                if (v >= thr) begin
                    m_vmem = 0; m_fire = 1; m_refr_left = RTICKS;
                end else begin
                    m_vmem = v; m_fire = 0;
                end
            end
            if (c) begin
                m_weight = w;
                m_vth = th;
            end
        end
        exp_q.push_back({(m_refr_left > 0), m_fire, WIDTH'(m_vmem)});
    endtask

    // driver tasks
    task automatic drive(input bit r, input bit s, input bit c,
                         input int w, input int th);
        @(negedge clk);
        rst = r;
        nrn_if.spike_i = s;
        nrn_if.cfg_load_i = c;
        nrn_if.weight_i = WIDTH'(w);
        nrn_if.vth_i = WIDTH'(th);
        model_step(r, s, c, w, th);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
    endtask

    task automatic pulse();
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(0, i[0], 0, 0, 0);
    endtask

    task automatic do_cfg(input int w, input int th);
        drive(1, 0, 1, w, th);
    endtask

    // monitor / scoreboard
    logic [EW-1:0] exp_v, got_v;
    logic prev_spk = 1'b0;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {nrn_if.refractory_o, nrn_if.spike_o, nrn_if.vmem_o};
                n_cmp++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t: got vmem=%0d spike=%0b refr=%0b, expected vmem=%0d spike=%0b refr=%0b",
                             $time, got_v[WIDTH-1:0], got_v[WIDTH], got_v[WIDTH+1],
                             exp_v[WIDTH-1:0], exp_v[WIDTH], exp_v[WIDTH+1]);
                end
                if (nrn_if.spike_o === 1'b1) begin
                    n_cmp++;
                    if (prev_spk === 1'b1) begin
                        n_fail++;
                        $display("FAIL back_to_back_spike t=%0t: spike_o=1 on two consecutive cycles, required a gap",
                                 $time);
                    end
                end
                prev_spk = nrn_if.spike_o;
            end
        end
    end

    // stimulus
    initial begin : stimulus
        int r;
        rst = 1'b0;
        nrn_if.spike_i = 1'b0;
        nrn_if.cfg_load_i = 1'b0;
        nrn_if.weight_i = '0;
        nrn_if.vth_i = '0;

        do_reset(2);
        for (int i = 0; i < 5; i++) pulse();
        idle(3);
        for (int i = 0; i < 3; i++) pulse();
        idle(40);
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0);
        idle(2);
        pulse();
        for (int i = 0; i < 4; i++) pulse();
        idle(30);
        for (int i = 0; i < 3; i++) pulse();
        pulse(); pulse();
        idle(5);
        do_reset(2);
        idle(2);

        do_cfg(40000, 65535);
        pulse(); pulse();
        idle(45);
        do_cfg(5, 0);
        pulse();
        idle(45);
        do_cfg(30, 500);
        for (int i = 0; i < 6; i++) pulse();
        do_cfg(30, 50);
        idle(45);
        do_cfg(DEF_W, DEF_TH);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                drive(0, $urandom_range(0, 1), 0, 0, 0);
            end else if (r < 20) begin
                drive(1, $urandom_range(0, 1), 1,
                      ($urandom_range(0, 9) == 0) ? $urandom_range(30000, 65535) : $urandom_range(0, 300),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 1000));
            end else begin
                drive(1, ($urandom_range(0, 2) == 0), 0, 0, 0);
            end
        end
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Leaky integrate-and-fire neuron placed directly downstream of the ECG spike encoder.
- Consumes the encoder's spike output as its synaptic input.
- Integrates a programmable weight on each input spike and leaks the membrane on a divided time tick.
- Fires when the membrane reaches threshold, then enters a refractory period; its output feeds the next SNN layer.

Parameters:
- WIDTH, 16, membrane/weight/threshold width in bits, unsigned.
- TICK_DIV, 1200000, clk_i cycles per leak/refractory tick; minimum 1.
- LEAK_SHIFT, 3, leak per tick equals vmem >> LEAK_SHIFT.
- REFRACT_TICKS, 4, ticks spent in REFRACTORY after firing; 0 means no refractory period.
- DEFAULT_WEIGHT, 20, weight loaded at reset.
- DEFAULT_VTH, 100, threshold loaded at reset.

Ports:
- clk_i  in  1  single system clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-low reset.
- spike_i  in  1  input spike level from the encoder; may be held high for several cycles.
- weight_i  in  WIDTH  synaptic weight, captured when cfg_load_i=1.
- vth_i  in  WIDTH  firing threshold, captured when cfg_load_i=1.
- cfg_load_i  in  1  one-cycle config strobe.
- spike_o  out  1  one-cycle fire pulse, registered.
- vmem_o  out  WIDTH  current membrane potential, registered.
- refractory_o  out  1  high while in REFRACTORY.

Behaviour:
- Reset (rst_i=0 at a clk_i edge):
  - vmem=0, spike_o=0, refractory_o=0, state=INTEGRATE.
  - Tick counter=0, refractory counter=0, spike_d=0.
  - weight_r=DEFAULT_WEIGHT, vth_r=DEFAULT_VTH.
  - Reset overrides everything, including mid-refractory and a pending fire.
- Event detect:
  - spike_d registers spike_i every cycle.
  - event = spike_i & ~spike_d, so one event per rising edge; a held level counts once.
- Tick:
  - Free-running counter 0..TICK_DIV-1, independent of state.
  - tick=1 for exactly the cycle where counter==TICK_DIV-1; the counter then wraps to 0.
  - TICK_DIV=1 gives tick every cycle.
- Config:
  - cfg_load_i=1 loads weight_r/vth_r at that edge.
  - New values apply from the next cycle's computation.
  - vth_r=0 is treated as 1.
- INTEGRATE state, per cycle:
  - v1 = tick ? vmem - (vmem >> LEAK_SHIFT) : vmem.
  - v2 = event ? min(v1 + weight_r, 2^WIDTH-1) : v1. Compute in WIDTH+1 bits, then saturate.
  - Ordering when tick and event coincide: leak first, then add.
  - If v2 >= vth_r at the edge: vmem<=0, spike_o<=1 for one cycle.
    - If REFRACT_TICKS>0: state<=REFRACTORY, refractory counter<=REFRACT_TICKS, refractory_o<=1.
    - Otherwise stay in INTEGRATE.
  - Else: vmem<=v2, spike_o<=0.
- Latency: the rising edge of spike_i sampled at edge n updates vmem_o and spike_o at edge n (visible in cycle n+1).
- REFRACTORY state:
  - vmem held at 0; events discarded (not queued); spike_o=0.
  - On each tick the counter decrements.
  - When a tick arrives with counter==1: state<=INTEGRATE, refractory_o<=0 at that edge. Events in the following cycle integrate normally.
  - cfg_load_i is still honoured in this state.
- No other states; an unreachable state encoding recovers to INTEGRATE.
- spike_o never asserts on two consecutive cycles when REFRACT_TICKS>0.

Test Plan:
1. Reset: drive rst_i=0 for 2 cycles with spike_i toggling -> vmem_o=0, spike_o=0, refractory_o=0; after release a config readback via integration uses weight 20, vth 100.
2. Integration/fire (TICK_DIV=1000, no tick during test): 5 isolated spike_i pulses -> vmem_o 20,40,60,80, then spike_o one-cycle pulse on the 5th edge, vmem_o=0, refractory_o=1.
3. Held input: spike_i high for 10 cycles -> exactly one integration, vmem_o=20; no further change until spike_i falls and rises again.
4. Leak (TICK_DIV=8, LEAK_SHIFT=3): vmem_o=80, no input -> 70 after the next tick, then 62, then 55. Event coincident with a tick at vmem 70 -> 62+20=82.
5. Refractory (REFRACT_TICKS=4, TICK_DIV=8):
   - After a fire, pulses on spike_i are ignored, with vmem_o held at 0.
   - refractory_o drops on the 4th tick edge, and the next event gives vmem_o=20.
   - rst_i=0 asserted mid-refractory clears refractory_o the next cycle.
6. Saturation/config (WIDTH=8): cfg_load_i with weight 200, vth 255.
   - 2 events -> sum clamps to 255 >= 255 -> spike_o pulse.
   - cfg_load_i with vth 0 -> the next single event fires (threshold treated as 1).
